// File: rtl/lcd_scene_if.sv
// Handshake bundle between the scene sequencer and the LCD top level.
// The master side is the sequencer; the slave side is the surrounding logic.
interface lcd_scene_if #(
    parameter int MODE_W = 4
);
    logic              init_done;
    logic              frame_done;
    logic              next_req;
    logic              pause;
    logic [MODE_W-1:0] mode;
    logic              sub_rst_n;
    logic              scene_active;
    logic              mode_wrap;
    logic              timeout_err;

    modport master (
        input  init_done, frame_done, next_req, pause,
        output mode, sub_rst_n, scene_active, mode_wrap, timeout_err
    );

    modport slave (
        output init_done, frame_done, next_req, pause,
        input  mode, sub_rst_n, scene_active, mode_wrap, timeout_err
    );
endinterface

// File: rtl/lcd_scene_sequencer.sv
// Scene controller for the ST7735 demo: steps mode through N_MODES scenes with dwell,
// manual advance, pause and a fixed-width restart pulse. Define LCD_SCENE_TIMEOUT_EN for the draw watchdog.
module lcd_scene_sequencer #(
    parameter int N_MODES        = 10,
    parameter int MODE_W         = 4,
    parameter int DWELL_CYCLES   = 135_000_000,
    parameter int RST_PULSE      = 4,
    parameter int TIMEOUT_CYCLES = 2_700_000
) (
    input logic         sys_clk,
    input logic         sys_rst_n,
    lcd_scene_if.master bus
);
    localparam int DW = $clog2(DWELL_CYCLES + 1);
    localparam int RW = $clog2(RST_PULSE + 1);

    typedef enum logic [1:0] {IDLE, DRAW, HOLD, SWITCH} state_t;

    state_t            state_q;
    logic [MODE_W-1:0] mode_q;
    logic              sub_rst_n_q;
    logic              active_q;
    logic              wrap_q;
    logic              pend_q;
    logic [DW-1:0]     dwell_q;
    logic [RW-1:0]     rcnt_q;

    logic              mode_last_d;
    logic [MODE_W-1:0] mode_inc_d;

    assign mode_last_d = (mode_q == MODE_W'(N_MODES - 1));
    assign mode_inc_d  = mode_last_d ? '0 : mode_q + MODE_W'(1);

`ifdef LCD_SCENE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] wd_q;
    logic          terr_q;
    assign bus.timeout_err = terr_q;
`else
    assign bus.timeout_err = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= IDLE;
            mode_q      <= '0;
            sub_rst_n_q <= 1'b1;
            active_q    <= 1'b0;
            wrap_q      <= 1'b0;
            pend_q      <= 1'b0;
            dwell_q     <= '0;
            rcnt_q      <= '0;
`ifdef LCD_SCENE_TIMEOUT_EN
            wd_q        <= '0;
            terr_q      <= 1'b0;
`endif
        end else begin
            wrap_q <= 1'b0;
`ifdef LCD_SCENE_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (bus.init_done) begin
                        state_q  <= DRAW;
                        active_q <= 1'b1;
`ifdef LCD_SCENE_TIMEOUT_EN
                        wd_q     <= '0;
`endif
                    end
                end
                DRAW: begin
                    if (bus.next_req) pend_q <= 1'b1;
                    if (bus.frame_done) begin
                        active_q <= 1'b0;
                        if (pend_q || bus.next_req) begin
                            // manual advance already requested: skip the dwell entirely
                            state_q     <= SWITCH;
                            mode_q      <= mode_inc_d;
                            wrap_q      <= mode_last_d;
                            sub_rst_n_q <= 1'b0;
                            rcnt_q      <= '0;
                            pend_q      <= 1'b0;
                        end else begin
                            state_q <= HOLD;
                            dwell_q <= '0;
                        end
`ifdef LCD_SCENE_TIMEOUT_EN
                    end else if (wd_q == TW'(TIMEOUT_CYCLES - 1)) begin
                        // redraw the same scene after a restart
                        state_q     <= SWITCH;
                        terr_q      <= 1'b1;
                        active_q    <= 1'b0;
                        sub_rst_n_q <= 1'b0;
                        rcnt_q      <= '0;
                        pend_q      <= 1'b0;
                    end else begin
                        wd_q <= wd_q + TW'(1);
`endif
                    end
                end
                HOLD: begin
                    if (bus.next_req ||
                        (!bus.pause && dwell_q == DW'(DWELL_CYCLES - 1))) begin
                        state_q     <= SWITCH;
                        mode_q      <= mode_inc_d;
                        wrap_q      <= mode_last_d;
                        sub_rst_n_q <= 1'b0;
                        rcnt_q      <= '0;
                        pend_q      <= 1'b0;
                    end else if (!bus.pause) begin
                        dwell_q <= dwell_q + DW'(1);
                    end
                end
                SWITCH: begin
                    pend_q <= 1'b0;
                    if (rcnt_q == RW'(RST_PULSE - 1)) begin
                        state_q     <= DRAW;
                        sub_rst_n_q <= 1'b1;
                        active_q    <= 1'b1;
`ifdef LCD_SCENE_TIMEOUT_EN
                        wd_q        <= '0;
`endif
                    end else begin
                        rcnt_q <= rcnt_q + RW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.mode         = mode_q;
    assign bus.sub_rst_n    = sub_rst_n_q;
    assign bus.scene_active = active_q;
    assign bus.mode_wrap    = wrap_q;
endmodule

// File: tb/tb_lcd_scene_sequencer.sv
// Directed bench for lcd_scene_sequencer with N_MODES=3, DWELL_CYCLES=10, RST_PULSE=2, TIMEOUT_CYCLES=20.
module tb_lcd_scene_sequencer;
    logic sys_clk = 1'b0;
    logic sys_rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 sys_clk = ~sys_clk;

    lcd_scene_if #(.MODE_W(4)) bus ();

    lcd_scene_sequencer #(
        .N_MODES(3), .MODE_W(4), .DWELL_CYCLES(10), .RST_PULSE(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus      (bus.master)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge sys_clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode, sub_rst_n, scene_active, mode_wrap in one shot
    task automatic chk_all(input string tag, input int m, input logic sr, input logic sa, input logic w);
        chk({tag, ".mode"}, 32'(bus.mode), 32'(m));
        chk({tag, ".sub_rst_n"}, 32'(bus.sub_rst_n), 32'(sr));
        chk({tag, ".scene_active"}, 32'(bus.scene_active), 32'(sa));
        chk({tag, ".mode_wrap"}, 32'(bus.mode_wrap), 32'(w));
    endtask

    initial begin
        sys_rst_n      = 1'b0;
        bus.init_done  = 1'b0;
        bus.frame_done = 1'b0;
        bus.next_req   = 1'b0;
        bus.pause      = 1'b0;
        step(2);
        sys_rst_n = 1'b1;
        step();
        chk_all("reset", 0, 1, 0, 0);
        chk("reset.timeout_err", 32'(bus.timeout_err), 0);

        // idle waits for init_done
        step(2);
        chk_all("idle_wait", 0, 1, 0, 0);
        bus.init_done = 1'b1;
        step();
        chk_all("idle_to_draw", 0, 1, 1, 0);
        bus.init_done = 1'b0;

        // first scene: dwell of 10 cycles, stray frame_done in HOLD ignored
        step(2);
        bus.frame_done = 1'b1;
        step();
        bus.frame_done = 1'b0;
        chk_all("hold_entry", 0, 1, 0, 0);
        for (int i = 1; i <= 9; i++) begin
            bus.frame_done = (i == 3);
            step();
        end
        bus.frame_done = 1'b0;
        chk_all("hold_last", 0, 1, 0, 0);
        step();
        chk_all("switch1_a", 1, 0, 0, 0);
        step();
        chk_all("switch1_b", 1, 0, 0, 0);
        step();
        chk_all("draw1", 1, 1, 1, 0);

        // scenes 1 -> 2 -> 0 with wrap
        bus.frame_done = 1'b1; step(); bus.frame_done = 1'b0;
        step(10);
        chk_all("switch2", 2, 0, 0, 0);
        step(2);
        bus.frame_done = 1'b1; step(); bus.frame_done = 1'b0;
        step(10);
        chk_all("wrap", 0, 0, 0, 1);
        step();
        chk_all("wrap_end", 0, 0, 0, 0);
        step();
        chk_all("draw0", 0, 1, 1, 0);

        // pause 7 cycles: SWITCH 17 cycles after HOLD entry
        bus.frame_done = 1'b1; step(); bus.frame_done = 1'b0;
        bus.pause = 1'b1;
        step(7);
        bus.pause = 1'b0;
        step(9);
        chk_all("pause_hold16", 0, 1, 0, 0);
        step();
        chk_all("pause_switch17", 1, 0, 0, 0);
        step(2);
        chk_all("pause_draw", 1, 1, 1, 0);

        // next_req in DRAW, frame_done 5 cycles later skips HOLD
        bus.next_req = 1'b1; step(); bus.next_req = 1'b0;
        step(4);
        chk_all("pend_draw", 1, 1, 1, 0);
        bus.frame_done = 1'b1; step(); bus.frame_done = 1'b0;
        chk_all("pend_skip", 2, 0, 0, 0);
        step(2);
        chk_all("pend_draw2", 2, 1, 1, 0);

        // next_req and frame_done in the same cycle
        bus.next_req = 1'b1; bus.frame_done = 1'b1; step();
        bus.next_req = 1'b0; bus.frame_done = 1'b0;
        chk_all("same_cycle", 0, 0, 0, 1);
        step(2);
        chk_all("same_draw", 0, 1, 1, 0);

        // pending flag cleared: plain frame_done enters HOLD
        bus.frame_done = 1'b1; step(); bus.frame_done = 1'b0;
        chk_all("pend_cleared", 0, 1, 0, 0);
        step(3);
        // next_req in HOLD: SWITCH one cycle later; next_req in SWITCH ignored
        bus.next_req = 1'b1; step();
        chk_all("hold_next", 1, 0, 0, 0);
        step(); bus.next_req = 1'b0;
        chk_all("switch_next_ign", 1, 0, 0, 0);
        step();
        chk_all("switch_next_draw", 1, 1, 1, 0);

        // reset in SWITCH
        bus.next_req = 1'b1; bus.frame_done = 1'b1; step();
        bus.next_req = 1'b0; bus.frame_done = 1'b0;
        chk_all("pre_rst_switch", 2, 0, 0, 0);
        sys_rst_n = 1'b0; step(); sys_rst_n = 1'b1;
        chk_all("mid_rst", 0, 1, 0, 0);
        step(3);
        chk_all("mid_rst_idle", 0, 1, 0, 0);
        bus.init_done = 1'b1; step(); bus.init_done = 1'b0;
        chk_all("rst_redraw", 0, 1, 1, 0);

        // no frame_done: watchdog if built, otherwise wait indefinitely
`ifdef LCD_SCENE_TIMEOUT_EN
        step(19);
        chk("wd_before", 32'(bus.timeout_err), 0);
        chk_all("wd_before_st", 0, 1, 1, 0);
        step();
        chk("wd_pulse", 32'(bus.timeout_err), 1);
        chk_all("wd_switch", 0, 0, 0, 0);
        step();
        chk("wd_pulse_end", 32'(bus.timeout_err), 0);
        chk_all("wd_switch_b", 0, 0, 0, 0);
        step();
        chk_all("wd_redraw", 0, 1, 1, 0);
`else
        step(30);
        chk("no_wd_err", 32'(bus.timeout_err), 0);
        chk_all("no_wd_draw", 0, 1, 1, 0);
`endif

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule

// File: doc/lcd_scene_sequencer.md
# lcd_scene_sequencer

Parametrised scene controller for the ST7735 SPI LCD demo. It replaces the fixed 5-second mode counter and mode-change edge detector in the top level. After LCD initialisation it steps a mode index through `N_MODES` scenes and waits for each scene to finish drawing. It then holds the scene for a programmable dwell time, supports manual advance and pause, and issues a clean, fixed-width restart pulse to the drawing pipeline (mux, SPI writer, string/char generators) on every scene change.

## Interface
Parameters:
- `N_MODES`, 10: number of scenes; mode counts 0..N_MODES-1. Must be >=2.
- `MODE_W`, 4: width of `mode`. Requires N_MODES <= 2**MODE_W.
- `DWELL_CYCLES`, 135_000_000: hold time per scene in `sys_clk` cycles (5 s at 27 MHz). Must be >=1.
- `RST_PULSE`, 4: `sub_rst_n` low time in cycles. Must be >=1.
- `TIMEOUT_CYCLES`, 2_700_000: draw watchdog limit; used only with `LCD_SCENE_TIMEOUT_EN`.

Ports:
- `sys_clk` in 1: system clock (PLL output).
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `init_done` in 1: level; LCD init sequence complete.
- `frame_done` in 1: one-cycle pulse; current scene fully written.
- `next_req` in 1: one-cycle pulse; manual advance request.
- `pause` in 1: level; freezes the dwell counter.
- `mode` out MODE_W: current scene index, registered.
- `sub_rst_n` out 1: active-low restart for the drawing pipeline, registered.
- `scene_active` out 1: high while in DRAW.
- `mode_wrap` out 1: one-cycle pulse when mode goes N_MODES-1 -> 0.
- `timeout_err` out 1: one-cycle pulse on watchdog expiry (tied 0 without the macro).

## Operation
- Reset values: state IDLE, `mode`=0, `sub_rst_n`=1, `scene_active`=0, `mode_wrap`=0, `timeout_err`=0, dwell counter 0, pending flag 0.
- IDLE: wait for `init_done`=1, then go to DRAW. `sub_rst_n` stays 1 so the init path through the mux and writer runs.
- DRAW: `scene_active`=1.
  - `frame_done` goes to HOLD and clears the dwell counter.
  - A `next_req` seen here sets the pending flag.
  - If `frame_done` arrives with the pending flag set, or in the same cycle as `next_req`, go straight to SWITCH and skip HOLD.
- HOLD: the dwell counter increments each cycle while `pause`=0 and freezes while `pause`=1.
  - When the counter reaches DWELL_CYCLES-1 on an unpaused cycle, go to SWITCH.
  - `next_req` goes to SWITCH on the next cycle, regardless of `pause`.
- SWITCH:
  - On entry, `mode` takes (mode+1) mod N_MODES, and `mode_wrap` pulses if it wrapped.
  - `sub_rst_n`=0 for exactly RST_PULSE cycles, then 1, with the state back in DRAW.
  - The pending flag clears.
  - `next_req` during SWITCH is ignored.
- `frame_done` outside DRAW is ignored. After leaving IDLE, `init_done` is ignored.
- Dwell counter width is $clog2(DWELL_CYCLES+1). It never exceeds DWELL_CYCLES-1.
- A synchronous reset asserted mid-operation, in any state, returns every output to its reset value on the next edge.

## Timing
- All outputs are registered. `mode` changes on the same edge that `sub_rst_n` first goes low.
- IDLE -> DRAW: 1 cycle after `init_done` is sampled high.
- HOLD lasts exactly DWELL_CYCLES unpaused cycles. Each paused cycle adds one cycle.
- DRAW is re-entered RST_PULSE cycles after SWITCH entry. Downstream blocks see a full RST_PULSE-cycle synchronous reset with the new `mode` already stable.
- `next_req` in HOLD: SWITCH is entered 1 cycle later.

## Configuration
- `LCD_SCENE_TIMEOUT_EN` defined: a watchdog counts cycles in DRAW. If `frame_done` has not arrived after TIMEOUT_CYCLES, the block:
  - pulses `timeout_err` for one cycle;
  - enters SWITCH without incrementing `mode`, so the same scene redraws after a restart pulse.
- Not defined: no watchdog logic is built, `timeout_err` is constant 0, and DRAW waits indefinitely.

## Test plan
All scenarios use N_MODES=3, DWELL_CYCLES=10, RST_PULSE=2, TIMEOUT_CYCLES=20.
- Reset, `init_done` high at cycle 5, `frame_done` at cycle 8 -> HOLD for 10 cycles, then `mode`=1 with `sub_rst_n` low for exactly 2 cycles.
- Three full scene cycles -> `mode` sequence 0,1,2,0 with a single `mode_wrap` pulse coinciding with `mode`=0.
- `pause` high for 7 cycles during HOLD -> SWITCH entered 17 cycles after HOLD entry.
- `next_req` in DRAW, `frame_done` 5 cycles later -> HOLD skipped, `mode` increments 1 cycle after `frame_done`. Separately, `next_req` and `frame_done` in the same cycle -> same result.
- `sys_rst_n` low for one cycle during SWITCH -> `mode`=0, `sub_rst_n`=1, state IDLE; a new `init_done` is required before DRAW.
- With `LCD_SCENE_TIMEOUT_EN` and no `frame_done` -> `timeout_err` pulses after 20 DRAW cycles, `sub_rst_n` goes low for 2 cycles, and `mode` is unchanged.
